// File: rtl/add_pipe_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package add_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int SAT_W = 64;

  function automatic int chunk_w(int width, int stages);
    return width / stages;
  endfunction

  // Callers truncate to their own WIDTH.
  function automatic logic [SAT_W-1:0] SAT_MAX(int width);
    return (SAT_W'(1) << (width - 1)) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] SAT_MIN(int width);
    return SAT_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
interface add_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );
endinterface

// File: rtl/add_chunk.sv
// CW-bit ripple chain; also exposes the carry into its MSB for overflow detection.
module add_chunk #(parameter int CW = 4) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);
  logic [CW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout     = c[CW];
  assign c_msb_in = c[CW-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used by the ripple chunks.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/add_pipe.sv
// Pipelined add/sub: one CW-bit chunk per stage, carry registered between stages.
// Define ADD_PIPE_SAT_EN to clamp signed overflow to the signed extremes.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic  clk,
  input  logic  reset,
  add_pipe_if.slave bus
);
  localparam int CW = chunk_w(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("add_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic              adv;
  logic [STAGES:0]   vld_pipe;
  logic [WIDTH-1:0]  b_x;
  logic              c_in0;
  logic [WIDTH-1:0]  raw_sum;
  logic [WIDTH-1:0]  fin_sum;
  logic              raw_c;
  logic              raw_v;

  // Whole pipe freezes only when a finished result is being held back.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  assign vld_pipe[0]   = bus.in_valid;
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    vld_pipe[STAGES:1] <= '0;
    else if (adv) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign b_x   = (bus.in_sub == OP_ADD) ? bus.in_b : ~bus.in_b;
  assign c_in0 = (bus.in_sub == OP_SUB);

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Stage k sees only the operand chunks it and later stages still need.
    localparam int RW = WIDTH - k * CW;

    logic [RW-1:0]         a_i;
    logic [RW-1:0]         b_i;
    logic                  c_i;
    logic [CW-1:0]         s;
    logic                  co;
    logic                  cm;
    logic [(k+1)*CW-1:0]   acc;

    add_chunk #(.CW(CW)) u_chunk (
      .a       (a_i[CW-1:0]),
      .b       (b_i[CW-1:0]),
      .cin     (c_i),
      .sum     (s),
      .cout    (co),
      .c_msb_in(cm)
    );

    if (k == 0) begin : g_head
      assign a_i = bus.in_a;
      assign b_i = b_x;
      assign c_i = c_in0;
      assign acc = s;
    end else begin : g_body
      logic [k*CW-1:0] s_lo;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_i  <= '0;
          b_i  <= '0;
          c_i  <= 1'b0;
          s_lo <= '0;
        end else if (adv) begin
          a_i  <= g_st[k-1].a_i[RW+CW-1:CW];
          b_i  <= g_st[k-1].b_i[RW+CW-1:CW];
          c_i  <= g_st[k-1].co;
          s_lo <= g_st[k-1].acc;
        end
      end

      assign acc = {s, s_lo};
    end

    if (k == STAGES - 1) begin : g_tail
      assign raw_sum = acc;
      assign raw_c   = co;
      assign raw_v   = co ^ cm;
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = cm;
    end
  end

`ifdef ADD_PIPE_SAT_EN
  // A wrong-sign MSB on overflow tells which way the result ran off.
  assign fin_sum = !raw_v ? raw_sum :
                   (raw_sum[WIDTH-1] ? WIDTH'(SAT_MAX(WIDTH)) : WIDTH'(SAT_MIN(WIDTH)));
`else
  assign fin_sum = raw_sum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_sum   <= '0;
      bus.out_carry <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_zero  <= 1'b0;
    end else if (adv) begin
      bus.out_sum   <= fin_sum;
      bus.out_carry <= raw_c;
      bus.out_ovf   <= raw_v;
      bus.out_zero  <= (fin_sum == '0);
    end
  end
endmodule

// File: tb/tb_add_pipe.sv
// Drives STAGES=4, 1 and 16 copies of add_pipe in lockstep against hand-computed vectors.
module tb_add_pipe;
  import add_pipe_pkg::*;

`ifdef ADD_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s_wrap;
    logic [15:0] s_sat;
    logic        c;
    logic        v;
  } vec_t;

  logic clk;
  logic reset;
  logic in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic in_sub;
  logic out_ready;

  logic [2:0]       o_valid;
  logic [2:0]       o_rdy;
  logic [2:0]       o_carry;
  logic [2:0]       o_ovf;
  logic [2:0]       o_zero;
  logic [2:0][15:0] o_sum;

  vec_t tbl [14];
  int   exp_q [3][$];
  int   cyc_q [3][$];
  int   cyc;
  int   cur_idx;
  bit   lat_chk;
  int   total;
  int   bad;

  function automatic int st_of(int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

  function automatic logic [15:0] exp_sum(int idx);
    return SAT ? tbl[idx].s_sat : tbl[idx].s_wrap;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int ST = (i == 0) ? 4 : (i == 1) ? 1 : 16;
    add_pipe_if #(.WIDTH(16)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in_a      = in_a;
    assign bus.in_b      = in_b;
    assign bus.in_sub    = in_sub;
    assign bus.out_ready = out_ready;

    assign o_valid[i] = bus.out_valid;
    assign o_rdy[i]   = bus.in_ready;
    assign o_sum[i]   = bus.out_sum;
    assign o_carry[i] = bus.out_carry;
    assign o_ovf[i]   = bus.out_ovf;
    assign o_zero[i]  = bus.out_zero;

    add_pipe #(.WIDTH(16), .STAGES(ST)) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: record accepted ops, check every presented result.
  always @(negedge clk) begin
    int j;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (in_valid && o_rdy[i]) begin
          exp_q[i].push_back(cur_idx);
          cyc_q[i].push_back(cyc);
        end
        if (o_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("d%0d_stale", i), 32'(o_valid[i]), 0);
          end else begin
            j = exp_q[i][0];
            chk($sformatf("d%0d_op%0d_sum", i, j), 32'(o_sum[i]), 32'(exp_sum(j)));
            chk($sformatf("d%0d_op%0d_carry", i, j), 32'(o_carry[i]), 32'(tbl[j].c));
            chk($sformatf("d%0d_op%0d_ovf", i, j), 32'(o_ovf[i]), 32'(tbl[j].v));
            chk($sformatf("d%0d_op%0d_zero", i, j), 32'(o_zero[i]), 32'(exp_sum(j) == 16'h0));
            if (out_ready) begin
              if (lat_chk)
                chk($sformatf("d%0d_op%0d_lat", i, j), 32'(cyc - cyc_q[i][0]), 32'(st_of(i)));
              void'(exp_q[i].pop_front());
              void'(cyc_q[i].pop_front());
            end else begin
              chk($sformatf("d%0d_hold_rdy", i), 32'(o_rdy[i]), 0);
            end
          end
        end
      end
    end
  end

  task automatic send(input int idx);
    in_valid = 1'b1;
    in_a     = tbl[idx].a;
    in_b     = tbl[idx].b;
    in_sub   = tbl[idx].sub;
    cur_idx  = idx;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d_drain", i), 32'(exp_q[i].size()), 0);
    idle(2);
  endtask

  initial begin
    //            a         b         op      wrap      sat       c     v
    tbl[0]  = '{16'h1234, 16'h4321, OP_ADD, 16'h5555, 16'h5555, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[2]  = '{16'h0005, 16'h0007, OP_SUB, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    tbl[4]  = '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
    tbl[5]  = '{16'h0001, 16'h0002, OP_ADD, 16'h0003, 16'h0003, 1'b0, 1'b0};
    tbl[6]  = '{16'h00FF, 16'h0001, OP_ADD, 16'h0100, 16'h0100, 1'b0, 1'b0};
    tbl[7]  = '{16'h0F0F, 16'hF0F0, OP_ADD, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[8]  = '{16'h1000, 16'h1000, OP_SUB, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0001, OP_SUB, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    tbl[10] = '{16'h8000, 16'h8000, OP_ADD, 16'h0000, 16'h8000, 1'b1, 1'b1};
    tbl[11] = '{16'h4000, 16'h4000, OP_ADD, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    tbl[12] = '{16'hABCD, 16'h1234, OP_SUB, 16'h9999, 16'h9999, 1'b1, 1'b0};
    tbl[13] = '{16'h0001, 16'h0001, OP_ADD, 16'h0002, 16'h0002, 1'b0, 1'b0};

    total = 0; bad = 0; cur_idx = 0; lat_chk = 1'b1;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = OP_ADD; out_ready = 1'b1;

    idle(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_rst_valid", i), 32'(o_valid[i]), 0);
      chk($sformatf("d%0d_rst_sum", i),   32'(o_sum[i]), 0);
      chk($sformatf("d%0d_rst_carry", i), 32'(o_carry[i]), 0);
      chk($sformatf("d%0d_rst_ovf", i),   32'(o_ovf[i]), 0);
      chk($sformatf("d%0d_rst_zero", i),  32'(o_zero[i]), 0);
      chk($sformatf("d%0d_rst_rdy", i),   32'(o_rdy[i]), 1);
    end
    reset = 1'b0;
    idle(2);

    // basic add, wrap to zero, subtract with borrow, overflow both ways
    send(0); drain();
    send(1); send(2); drain();
    send(3); send(4); drain();

    // back-to-back stream, then stall the consumer
    for (int k = 5; k <= 12; k++) send(k);
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("d0_rdy_drop", 32'(o_rdy[0]), 0);
    chk("d0_stall_valid", 32'(o_valid[0]), 1);
    idle(3);
    chk("d0_stall_sum", 32'(o_sum[0]), 32'(exp_sum(9)));
    out_ready = 1'b1;
    #1;
    chk("d0_rdy_comb", 32'(o_rdy[0]), 1);
    drain();
    lat_chk = 1'b1;

    // reset with ops in flight
    send(5); send(6); send(7);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_mid_rst_valid", i), 32'(o_valid[i]), 0);
      chk($sformatf("d%0d_mid_rst_sum", i),   32'(o_sum[i]), 0);
      chk($sformatf("d%0d_mid_rst_flags", i), 32'({o_carry[i], o_ovf[i], o_zero[i]}), 0);
      exp_q[i].delete();
      cyc_q[i].delete();
    end
    idle(2);
    reset = 1'b0;
    idle(20);
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d_post_rst_valid", i), 32'(o_valid[i]), 0);
    send(13); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
